// File: rtl/audio_mem_arbiter.sv
// Arbitrates the single-port sample/data memory between the CPU data port and the audio mixer.
// Optional build macro AUDIO_WRITE_PROTECT_EN blocks CPU writes into the audio sample region.
module audio_mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [ADDR_WIDTH-1:0] AUDIO_REGION_BASE = 18'h10000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wr_data,
  output logic                  cpu_gnt,
  output logic                  cpu_rd_valid,
  output logic [DATA_WIDTH-1:0] cpu_rd_data,
  input  logic                  aud_req,
  input  logic [ADDR_WIDTH-1:0] aud_addr,
  output logic                  aud_gnt,
  output logic                  aud_rd_valid,
  output logic [DATA_WIDTH-1:0] aud_rd_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  prot_err
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_CPU_RD = 2'd1,
    OWN_AUD_RD = 2'd2
  } owner_t;

  owner_t                owner, owner_nxt;
  logic [3:0]            starve_cnt;
  logic                  cpu_starved;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [DATA_WIDTH-1:0] cpu_data_q;
  logic [DATA_WIDTH-1:0] aud_data_q;
  logic                  in_region;
  logic                  wr_blocked;

  // Audio wins by default; the CPU only preempts once it has been starved LIMIT times.
  assign cpu_starved = cpu_req && (starve_cnt == LIMIT);
  assign cpu_gnt     = reset_n && cpu_req && (!aud_req || cpu_starved);
  assign aud_gnt     = reset_n && aud_req && !cpu_starved;

  assign in_region = (cpu_addr >= AUDIO_REGION_BASE);

`ifdef AUDIO_WRITE_PROTECT_EN
  logic prot_q;

  assign wr_blocked = cpu_gnt && cpu_we && in_region;
  assign prot_err   = prot_q;

  always_ff @(posedge clk) begin
    if (!reset_n)
      prot_q <= 1'b0;
    else if (wr_blocked)
      prot_q <= 1'b1;
  end
`else
  assign wr_blocked = 1'b0 & in_region;
  assign prot_err   = 1'b0;
`endif

  // With no grant the memory port keeps presenting the last issued address/data.
  assign mem_addr    = cpu_gnt ? cpu_addr : (aud_gnt ? aud_addr : addr_q);
  assign mem_wr_data = cpu_gnt ? cpu_wr_data : wr_data_q;
  assign mem_we      = cpu_gnt && cpu_we && !wr_blocked;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q    <= '0;
      wr_data_q <= '0;
    end else begin
      if (cpu_gnt || aud_gnt)
        addr_q <= mem_addr;
      if (cpu_gnt)
        wr_data_q <= cpu_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      starve_cnt <= '0;
    else if (cpu_gnt || !cpu_req)
      starve_cnt <= '0;
    else if (aud_gnt && (starve_cnt < LIMIT))
      starve_cnt <= starve_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      owner <= OWN_NONE;
    else
      owner <= owner_nxt;
  end

  always_comb begin
    owner_nxt = OWN_NONE;
    if (cpu_gnt && !cpu_we)
      owner_nxt = OWN_CPU_RD;
    else if (aud_gnt)
      owner_nxt = OWN_AUD_RD;
  end

  assign cpu_rd_valid = (owner == OWN_CPU_RD);
  assign aud_rd_valid = (owner == OWN_AUD_RD);

  // Read data passes straight through in the valid cycle and is held afterwards.
  assign cpu_rd_data = cpu_rd_valid ? mem_rd_data : cpu_data_q;
  assign aud_rd_data = aud_rd_valid ? mem_rd_data : aud_data_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cpu_data_q <= '0;
      aud_data_q <= '0;
    end else begin
      if (cpu_rd_valid)
        cpu_data_q <= mem_rd_data;
      if (aud_rd_valid)
        aud_data_q <= mem_rd_data;
    end
  end

endmodule

// File: tb/tb_audio_mem_arbiter.sv
// Directed bench for audio_mem_arbiter with a behavioural 1-cycle-latency memory.
// Expected values adapt to the AUDIO_WRITE_PROTECT_EN build macro.
module tb_audio_mem_arbiter;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 18;
`ifdef AUDIO_WRITE_PROTECT_EN
  localparam bit P = 1'b1;
`else
  localparam bit P = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cpu_req, cpu_we, aud_req;
  logic [AW-1:0] cpu_addr, aud_addr, mem_addr;
  logic [DW-1:0] cpu_wr_data, mem_wr_data, mem_rd_data, cpu_rd_data, aud_rd_data;
  logic          cpu_gnt, cpu_rd_valid, aud_gnt, aud_rd_valid, mem_we, prot_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  audio_mem_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .STARVE_LIMIT(4),
    .AUDIO_REGION_BASE(18'h10000)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
    .cpu_gnt(cpu_gnt), .cpu_rd_valid(cpu_rd_valid), .cpu_rd_data(cpu_rd_data),
    .aud_req(aud_req), .aud_addr(aud_addr), .aud_gnt(aud_gnt),
    .aud_rd_valid(aud_rd_valid), .aud_rd_data(aud_rd_data),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_we(mem_we),
    .mem_rd_data(mem_rd_data), .prot_err(prot_err)
  );

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  always @(posedge clk) begin
    if (mem_we)
      mem[mem_addr] <= mem_wr_data;
    mem_rd_data <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          cr, cw;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic          ar;
    logic [AW-1:0] aa;
    logic          g_c, g_a, we;
    logic [AW-1:0] addr;
    logic          cv, av;
    logic [DW-1:0] cdat, adat;
    logic          perr;
  } vec_t;

  function automatic vec_t mk(
      input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
      input logic ar, input logic [AW-1:0] aa,
      input logic g_c, input logic g_a, input logic we, input logic [AW-1:0] addr,
      input logic cv, input logic av, input logic [DW-1:0] cdat, input logic [DW-1:0] adat,
      input logic perr);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd; v.ar = ar; v.aa = aa;
    v.g_c = g_c; v.g_a = g_a; v.we = we; v.addr = addr;
    v.cv = cv; v.av = av; v.cdat = cdat; v.adat = adat; v.perr = perr;
    return v;
  endfunction

  task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cd, input logic ar, input logic [AW-1:0] aa);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wr_data = cd;
    aud_req = ar; aud_addr = aa;
  endtask

  vec_t vecs [27];

  initial begin
    logic [DW-1:0] pd;
    int            cpu_at;

    for (int i = 0; i < (1 << AW); i++) mem[i] = pat(AW'(i));
    pd = P ? pat(18'h10005) : 16'hDEAD;

    // cr cw ca cd ar aa | gc ga we addr cv av cdat adat perr
    vecs[0]  = mk(1,1,18'h10,16'hBEEF,0,0,        1,0,1,18'h10,   0,0,16'h0,16'h0,0);
    vecs[1]  = mk(1,0,18'h10,0,0,0,               1,0,0,18'h10,   0,0,16'h0,16'h0,0);
    vecs[2]  = mk(0,0,0,0,0,0,                    0,0,0,18'h10,   1,0,16'hBEEF,16'h0,0);
    vecs[3]  = mk(0,0,0,0,1,18'h10000,            0,1,0,18'h10000,0,0,16'hBEEF,16'h0,0);
    vecs[4]  = mk(0,0,0,0,1,18'h10001,            0,1,0,18'h10001,0,1,16'hBEEF,16'h5A5A,0);
    vecs[5]  = mk(0,0,0,0,0,0,                    0,0,0,18'h10001,0,1,16'hBEEF,16'h5A5B,0);
    vecs[6]  = mk(0,0,0,0,0,0,                    0,0,0,18'h10001,0,0,16'hBEEF,16'h5A5B,0);
    vecs[7]  = mk(1,0,18'h10,0,1,18'h10002,       0,1,0,18'h10002,0,0,16'hBEEF,16'h5A5B,0);
    vecs[8]  = mk(1,0,18'h10,0,1,18'h10002,       0,1,0,18'h10002,0,1,16'hBEEF,16'h5A58,0);
    vecs[9]  = vecs[8];
    vecs[10] = vecs[8];
    vecs[11] = mk(1,0,18'h10,0,1,18'h10002,       1,0,0,18'h10,   0,1,16'hBEEF,16'h5A58,0);
    vecs[12] = mk(0,0,0,0,0,0,                    0,0,0,18'h10,   1,0,16'hBEEF,16'h5A58,0);
    vecs[13] = mk(1,0,18'h10,0,1,18'h10002,       0,1,0,18'h10002,0,0,16'hBEEF,16'h5A58,0);
    vecs[14] = vecs[8];
    vecs[15] = vecs[8];
    vecs[16] = vecs[8];
    vecs[17] = vecs[11];
    vecs[18] = mk(0,0,0,0,0,0,                    0,0,0,18'h10,   1,0,16'hBEEF,16'h5A58,0);
    vecs[19] = mk(1,1,18'h20,16'h1234,1,18'h10002,0,1,0,18'h10002,0,0,16'hBEEF,16'h5A58,0);
    vecs[20] = mk(0,0,0,0,0,0,                    0,0,0,18'h10002,0,1,16'hBEEF,16'h5A58,0);
    vecs[21] = mk(1,0,18'h20,0,0,0,               1,0,0,18'h20,   0,0,16'hBEEF,16'h5A58,0);
    vecs[22] = mk(0,0,0,0,0,0,                    0,0,0,18'h20,   1,0,16'h5A7A,16'h5A58,0);
    vecs[23] = mk(1,1,18'h10005,16'hDEAD,0,0,     1,0,!P,18'h10005,0,0,16'h5A7A,16'h5A58,0);
    vecs[24] = mk(1,0,18'h10005,0,0,0,            1,0,0,18'h10005,0,0,16'h5A7A,16'h5A58,P);
    vecs[25] = mk(0,0,0,0,0,0,                    0,0,0,18'h10005,1,0,pd,16'h5A58,P);
    vecs[26] = mk(0,0,0,0,0,0,                    0,0,0,18'h10005,0,0,pd,16'h5A58,P);

    // Reset with both requesters active: grants must stay low.
    reset_n = 1'b0;
    drive(1,0,18'h10,0,1,18'h10000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_cpu_gnt", 32'(cpu_gnt), 0);
      chk("rst_aud_gnt", 32'(aud_gnt), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    drive(0,0,0,0,0,0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_cpu_rd_valid", 32'(cpu_rd_valid), 0);
      chk("idle_aud_rd_valid", 32'(aud_rd_valid), 0);
      chk("idle_prot_err", 32'(prot_err), 0);
      chk("idle_mem_we", 32'(mem_we), 0);
      chk("idle_gnts", 32'({cpu_gnt, aud_gnt}), 0);
    end

    for (int i = 0; i < 27; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd, vecs[i].ar, vecs[i].aa);
      @(negedge clk);
      chk($sformatf("v%0d_cpu_gnt", i), 32'(cpu_gnt), 32'(vecs[i].g_c));
      chk($sformatf("v%0d_aud_gnt", i), 32'(aud_gnt), 32'(vecs[i].g_a));
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].we));
      chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d_cpu_rd_valid", i), 32'(cpu_rd_valid), 32'(vecs[i].cv));
      chk($sformatf("v%0d_aud_rd_valid", i), 32'(aud_rd_valid), 32'(vecs[i].av));
      chk($sformatf("v%0d_cpu_rd_data", i), 32'(cpu_rd_data), 32'(vecs[i].cdat));
      chk($sformatf("v%0d_aud_rd_data", i), 32'(aud_rd_data), 32'(vecs[i].adat));
      chk($sformatf("v%0d_prot_err", i), 32'(prot_err), 32'(vecs[i].perr));
    end

    // Partially starve the CPU, then reset mid-operation: the counter must clear.
    @(posedge clk); #1;
    drive(1,0,18'h30,0,1,18'h10003);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_gnts", 32'({cpu_gnt, aud_gnt}), 0);
    chk("mid_rst_aud_rd_valid", 32'(aud_rd_valid), 1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_aud_rd_valid", 32'(aud_rd_valid), 0);
    chk("post_rst_prot_err", 32'(prot_err), 0);
    chk("post_rst_aud_rd_data", 32'(aud_rd_data), 0);

    // The cycle just checked is audio grant #1 after reset; CPU must win on the 5th.
    cpu_at = -1;
    for (int c = 0; c < 8 && cpu_at < 0; c++) begin
      if (c > 0) @(negedge clk);
      if (cpu_gnt) cpu_at = c;
      else chk($sformatf("post_rst_aud_gnt_c%0d", c), 32'(aud_gnt), 1);
    end
    chk("post_rst_cpu_gnt_cycle", 32'(cpu_at), 4);
    @(posedge clk); #1;
    drive(0,0,0,0,0,0);
    @(negedge clk);
    chk("post_rst_cpu_rd_valid", 32'(cpu_rd_valid), 1);
    chk("post_rst_cpu_rd_data", 32'(cpu_rd_data), 32'(pat(18'h30)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
